// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared RV32I/RV32M decode types: opcodes, ALU/compare ops, datapath mux
// selects, the registered control word and its idle/illegal default.
package decode_ctrl_pipe_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_fence = 7'b0001111,
        op_csr   = 7'b1110011
    } rv32i_opcode_t;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops_t;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        mul    = 3'b000,
        mulh   = 3'b001,
        mulhsu = 3'b010,
        mulhu  = 3'b011,
        div    = 3'b100,
        divu   = 3'b101,
        rem    = 3'b110,
        remu   = 3'b111
    } m_funct3_t;

    typedef enum logic [3:0] {
        regfilemux_alu_out,
        regfilemux_br_en,
        regfilemux_u_imm,
        regfilemux_lw,
        regfilemux_pc_plus4,
        regfilemux_lb,
        regfilemux_lbu,
        regfilemux_lh,
        regfilemux_lhu,
        regfilemux_muldiv_out
    } regfilemux_sel_t;

    typedef enum logic [0:0] {
        alumux1_rs1_out,
        alumux1_pc_out
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        alumux2_i_imm,
        alumux2_u_imm,
        alumux2_b_imm,
        alumux2_s_imm,
        alumux2_j_imm,
        alumux2_rs2_out
    } alumux2_sel_t;

    typedef enum logic [0:0] {
        cmpmux_rs2_out,
        cmpmux_i_imm
    } cmpmux_sel_t;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        alu_ops_t        aluop;
        branch_funct3_t  cmpop;
        alumux1_sel_t    alumux1_sel;
        alumux2_sel_t    alumux2_sel;
        cmpmux_sel_t     cmpmux_sel;
        regfilemux_sel_t regfilemux_sel;
        logic            load_regfile;
        logic            dmem_read;
        logic            dmem_write;
        logic            is_branch;
        logic            is_jump;
        logic            md_en;
        m_funct3_t       mdop;
    } rv32i_control_word;

    // Word that has no architectural side effect: no writeback, no memory access.
    localparam rv32i_control_word CTRL_DEFAULT = '{
        opcode:         7'h00,
        funct3:         3'h0,
        aluop:          alu_add,
        cmpop:          beq,
        alumux1_sel:    alumux1_rs1_out,
        alumux2_sel:    alumux2_i_imm,
        cmpmux_sel:     cmpmux_rs2_out,
        regfilemux_sel: regfilemux_alu_out,
        load_regfile:   1'b0,
        dmem_read:      1'b0,
        dmem_write:     1'b0,
        is_branch:      1'b0,
        is_jump:        1'b0,
        md_en:          1'b0,
        mdop:           mul
    };

    typedef enum logic [0:0] {
        StRun,
        StMdBusy
    } md_state_e;

    // div/divu/rem/remu all have funct3[2] set; they occupy the divider.
    function automatic logic md_is_div(input m_funct3_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational RV32I/RV32M decode: instruction word in, control word
// and illegal flag out. Illegal encodings always produce CTRL_DEFAULT.
module ctrl_decode
    import decode_ctrl_pipe_pkg::*;
#(
    parameter bit M_EXT = 1'b1
) (
    input  logic [31:0]       instr,
    output rv32i_control_word ctrl,
    output logic              illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_reg;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign is_reg        = (opcode == op_reg);
    // Register indices and immediates are extracted downstream from out_instr.
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // Opcode/funct3/funct7 decode with legality checks.
    always_comb begin
        ctrl        = CTRL_DEFAULT;
        illegal     = 1'b0;
        ctrl.opcode = opcode;
        ctrl.funct3 = funct3;

        case (opcode)
            op_lui: begin
                ctrl.load_regfile   = 1'b1;
                ctrl.regfilemux_sel = regfilemux_u_imm;
            end
            op_auipc: begin
                ctrl.load_regfile = 1'b1;
                ctrl.alumux1_sel  = alumux1_pc_out;
                ctrl.alumux2_sel  = alumux2_u_imm;
            end
            op_jal: begin
                ctrl.load_regfile   = 1'b1;
                ctrl.regfilemux_sel = regfilemux_pc_plus4;
                ctrl.alumux1_sel    = alumux1_pc_out;
                ctrl.alumux2_sel    = alumux2_j_imm;
                ctrl.is_jump        = 1'b1;
            end
            op_jalr: begin
                ctrl.load_regfile   = 1'b1;
                ctrl.regfilemux_sel = regfilemux_pc_plus4;
                ctrl.alumux2_sel    = alumux2_i_imm;
                ctrl.is_jump        = 1'b1;
            end
            op_br: begin
                ctrl.cmpop       = branch_funct3_t'(funct3);
                ctrl.alumux1_sel = alumux1_pc_out;
                ctrl.alumux2_sel = alumux2_b_imm;
                ctrl.is_branch   = 1'b1;
            end
            op_load: begin
                ctrl.load_regfile = 1'b1;
                ctrl.dmem_read    = 1'b1;
                ctrl.alumux2_sel  = alumux2_i_imm;
                case (funct3)
                    3'b000:  ctrl.regfilemux_sel = regfilemux_lb;
                    3'b001:  ctrl.regfilemux_sel = regfilemux_lh;
                    3'b100:  ctrl.regfilemux_sel = regfilemux_lbu;
                    3'b101:  ctrl.regfilemux_sel = regfilemux_lhu;
                    default: ctrl.regfilemux_sel = regfilemux_lw;
                endcase
            end
            op_store: begin
                ctrl.dmem_write  = 1'b1;
                ctrl.alumux2_sel = alumux2_s_imm;
            end
            op_fence, op_csr: begin
                // Accepted as no-ops: nothing written back, no memory access.
            end
            op_imm, op_reg: begin
                ctrl.load_regfile = 1'b1;
                ctrl.alumux2_sel  = is_reg ? alumux2_rs2_out : alumux2_i_imm;
                ctrl.cmpmux_sel   = is_reg ? cmpmux_rs2_out : cmpmux_i_imm;
                if (is_reg && funct7 == 7'h01) begin
                    if (M_EXT) begin
                        ctrl.md_en          = 1'b1;
                        ctrl.mdop           = m_funct3_t'(funct3);
                        ctrl.regfilemux_sel = regfilemux_muldiv_out;
                    end else begin
                        illegal = 1'b1;
                    end
                end else begin
                    if (is_reg) begin
                        if (!(funct7 == 7'h00 ||
                              (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
                            illegal = 1'b1;
                        end
                    end else if (funct3 == 3'b001) begin
                        if (funct7 != 7'h00) illegal = 1'b1;
                    end else if (funct3 == 3'b101) begin
                        if (funct7 != 7'h00 && funct7 != 7'h20) illegal = 1'b1;
                    end
                    case (funct3)
                        3'b000: ctrl.aluop = (is_reg && funct7[5]) ? alu_sub : alu_add;
                        3'b001: ctrl.aluop = alu_sll;
                        3'b010: begin
                            ctrl.cmpop          = blt;
                            ctrl.regfilemux_sel = regfilemux_br_en;
                        end
                        3'b011: begin
                            ctrl.cmpop          = bltu;
                            ctrl.regfilemux_sel = regfilemux_br_en;
                        end
                        3'b100: ctrl.aluop = alu_xor;
                        3'b101: ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
                        3'b110: ctrl.aluop = alu_or;
                        default: ctrl.aluop = alu_and;
                    endcase
                end
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            ctrl = CTRL_DEFAULT;
        end
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered decode stage between fetch and execute. Holds one decoded entry
// behind a valid/ready handshake and blocks issue while the non-pipelined
// multiply/divide unit is occupied by a word that has already left this stage.
module decode_ctrl_pipe
    import decode_ctrl_pipe_pkg::*;
#(
    parameter bit          M_EXT      = 1'b1,
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned PC_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output rv32i_control_word   out_ctrl,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [31:0]         out_instr,
    output logic                out_illegal
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
    localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

    rv32i_control_word   dec_ctrl;
    logic                dec_illegal;

    logic                out_valid_q;
    logic                out_illegal_q;
    rv32i_control_word   out_ctrl_q;
    logic [PC_WIDTH-1:0] out_pc_q;
    logic [31:0]         out_instr_q;

    md_state_e           state_q, state_d;
    logic [CntW-1:0]     busy_cnt_q, busy_cnt_d;

    logic                accept;
    logic                md_go;
    logic [CntW-1:0]     md_load;

    ctrl_decode #(
        .M_EXT (M_EXT)
    ) u_ctrl_decode (
        .instr   (in_instr),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // Handshake: only RUN issues, and only into an empty or draining register.
    always_comb begin
        in_ready = rst & ~flush & (state_q == StRun) & (~out_valid_q | out_ready);
        accept   = in_valid & in_ready;
        md_go    = out_valid_q & out_ready & out_ctrl_q.md_en & ~flush;
        md_load  = md_is_div(out_ctrl_q.mdop) ? DivLoad : MulLoad;
    end

    // Output register: flush kills the entry, accept loads, a take drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q   <= 1'b0;
            out_illegal_q <= 1'b0;
            out_ctrl_q    <= CTRL_DEFAULT;
            out_pc_q      <= '0;
            out_instr_q   <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_illegal_q <= dec_illegal;
            out_ctrl_q    <= dec_ctrl;
            out_pc_q      <= in_pc;
            out_instr_q   <= in_instr;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Busy FSM next state: an M word leaving the stage (re)loads the countdown.
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        if (md_go && md_load != '0) begin
            state_d    = StMdBusy;
            busy_cnt_d = md_load;
        end else if (state_q == StMdBusy) begin
            if (busy_cnt_q <= CntW'(1)) begin
                state_d    = StRun;
                busy_cnt_d = '0;
            end else begin
                busy_cnt_d = busy_cnt_q - CntW'(1);
            end
        end
    end

    // Busy FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StRun;
            busy_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_illegal = out_illegal_q;
    assign out_ctrl    = out_ctrl_q;
    assign out_pc      = out_pc_q;
    assign out_instr   = out_instr_q;

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered RV32I/RV32M decode stage that turns a fetched instruction into an `rv32i_control_word` behind a valid/ready handshake. It sits between fetch and execute. It supersedes purely combinational decode with:
- a one-cycle output register with backpressure,
- flush support,
- illegal-instruction flagging,
- a busy FSM that holds issue while the non-pipelined multiply/divide unit is occupied.

## Interface
- `M_EXT`, 1, enables RV32M decode; when 0, RV32M encodings are illegal.
- `MUL_CYCLES`, 3, cycles the mul unit is occupied per MUL/MULH/MULHSU/MULHU; must be ≥1.
- `DIV_CYCLES`, 33, cycles the div unit is occupied per DIV/DIVU/REM/REMU; must be ≥1.
- `PC_WIDTH`, 32, width of the PC sideband.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  PC_WIDTH  instruction PC.
- `flush`  in  1  kill the registered entry and block accept this cycle.
- `out_valid`  out  1  registered control word valid.
- `out_ready`  in  1  execute accepts.
- `out_ctrl`  out  rv32i_control_word  decoded control, including `opcode` and `funct3` copies.
- `out_pc`  out  PC_WIDTH  registered PC.
- `out_instr`  out  32  registered instruction, for immediates and register indices.
- `out_illegal`  out  1  registered entry is an illegal encoding.

## Operation
**Decode.** Follows the RV32I opcode/funct3/funct7 rules:
- `op_reg` funct7 must be 7'h00, 7'h20 (add/sub and srl/sra only), or 7'h01 (RV32M, only if `M_EXT`). Anything else is illegal.
- `op_imm` shift funct7 must be 7'h00 or 7'h20 (sra only). Anything else is illegal.
- Unknown opcode is illegal.
- An illegal entry carries the default word: `load_regfile`=0, `dmem_read`=0, `dmem_write`=0, `aluop`=alu_add.

**RV32M ops.**
- Set `ctrl.mdop` to the funct3 value.
- Set `regfilemux_sel` to muldiv_out.
- Set `load_regfile` to 1.

**Handshake.**
- Accept when `in_valid & in_ready`.
- `in_ready` = `rst` & !`flush` & (state==RUN) & (!`out_valid` | `out_ready`).
- On accept, the output register loads the decode of `in_instr` and sets `out_valid`=1.
- On `out_ready` without a new accept, `out_valid` clears to 0.
- Outputs are held stable while `out_valid & !out_ready`.

**Flush.**
- `out_valid` clears to 0 next edge. This overrides a simultaneous `out_ready` and a simultaneous input.
- Flush does not alter state or the counter, because the md unit stays occupied.

**FSM states.**
- RUN: the only state that permits accept.
- MD_BUSY: in_ready=0. `busy_cnt` decrements each cycle; go to RUN on the edge where `busy_cnt`==1.

**Entering MD_BUSY.**
- Trigger: an RV32M word transfers out (`out_valid & out_ready & mdop-valid & !flush`).
- Load `busy_cnt` with MUL_CYCLES-1 or DIV_CYCLES-1.
- If the load value is 0, stay in RUN.

**Counter.** `busy_cnt` width is $clog2(max(MUL_CYCLES,DIV_CYCLES)+1), unsigned, and never wraps.

**Reset.** Asserting `rst` low mid-operation immediately drives:
- `out_valid`=0, `out_illegal`=0;
- `out_ctrl`=default word, `out_pc`=0, `out_instr`=0;
- state=RUN, `busy_cnt`=0.

## Timing
- Latency: accept on edge N gives `out_valid`=1 after edge N.
- Throughput: 1 instruction/cycle for non-M ops with `out_ready`=1.
- After an M transfer on edge N, `in_ready`=0 for cycles N+1 … N+LAT-1, and accept resumes in cycle N+LAT.
- An accept and an output transfer in the same cycle are allowed when in RUN (back-to-back).
- An M word issued with `out_ready` stalled does not start the counter until it transfers.
- `in_ready` is combinational from `out_ready`, `flush` and state. No other combinational in→out paths.
- `in_ready`=0 while `rst`=0 and in the first cycle after deassertion only if `flush`=1.

## Structure
- Add to `rv32i_types`:
  - `m_funct3_t` (mul, mulh, mulhsu, mulhu, div, divu, rem, remu);
  - `regfilemux::muldiv_out`;
  - `mdop` and `md_en` fields in `rv32i_control_word`;
  - a `CTRL_DEFAULT` constant.
- The combinational decode is the sub-module `ctrl_decode`: instruction in, control word and illegal out. `decode_ctrl_pipe` owns the registers, handshake and FSM.

## Test plan
- Reset then `add x1,x2,x3` (32'h003100B3) with `out_ready`=1 → `out_valid` next cycle, `aluop`=alu_add, `load_regfile`=1, `in_ready` stays 1.
- `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, and `out_ctrl`/`out_pc` are unchanged across the stall.
- `mul x1,x2,x3` (32'h023100B3) transfers on edge N with MUL_CYCLES=3 → `in_ready`=0 for 2 cycles and accept resumes in cycle N+3. With DIV_CYCLES=33, `div` gives 32 cycles of stall.
- `flush` asserted while `out_valid`=1 and `out_ready`=1 → `out_valid`=0 next cycle. Flush during MD_BUSY does not shorten the stall.
- The following encodings → `out_illegal`=1, `load_regfile`=0, `dmem_write`=0:
  - opcode 7'b1111111;
  - `op_reg` with funct7=7'h40;
  - `mul` with M_EXT=0.
- Async reset pulse mid-MD_BUSY and mid-stall → all outputs reach reset values without a clock edge, and state is RUN after release.
